// File: rtl/vga_fill_engine.sv
// Bus-mapped pixel writer and solid-rectangle filler for the 100x75-cell
// framebuffer write port; cell (col,row) lives at row*100 + col + 1.
module vga_fill_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [2:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        write_enable,
    output logic [18:0] write_address,
    output logic [7:0]  write_data,
    output logic        done
);
    localparam logic [6:0] COLS = 7'd100;
    localparam logic [6:0] ROWS = 7'd75;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL} state_t;
    state_t state_q, state_d;

    logic [6:0]  x0_q, y0_q;
    logic [7:0]  w_q, h_q, color_q;
    logic [6:0]  sx_q, sy_q;
    logic [7:0]  sw_q, sh_q, scolor_q;
    logic [7:0]  ew_q, eh_q, col_q, row_q;
    logic [18:0] row_base_q;
    logic        pix_we_q;
    logic [18:0] pix_addr_q;
    logic [7:0]  pix_data_q;
    logic        done_q, drop_q, donef_q;
    logic [31:0] rdata_q;

    logic        busy, start, wr_pix, rd_status, pix_ok, fill_done;
    logic        empty, last_col, last_row;
    logic [7:0]  avail_w, avail_h, ew_d, eh_d;
    logic [18:0] base_d;
    logic [31:0] rdata_d;
    logic        unused_bits;

    assign unused_bits = ^bus_wdata[15:8];

    assign busy      = (state_q != S_IDLE);
    assign start     = bus_we && (bus_addr == 3'd3) && bus_wdata[0] && !busy;
    assign wr_pix    = bus_we && (bus_addr == 3'd4);
    assign rd_status = bus_re && (bus_addr == 3'd3);
    assign pix_ok    = (bus_wdata[6:0] < COLS) && (bus_wdata[22:16] < ROWS);

    // Clipping works on the shadow copies, so it is stable for the whole SETUP cycle.
    assign empty   = (sx_q >= COLS) || (sy_q >= ROWS) || (sw_q == 8'd0) || (sh_q == 8'd0);
    assign avail_w = {1'b0, COLS} - {1'b0, sx_q};
    assign avail_h = {1'b0, ROWS} - {1'b0, sy_q};
    assign ew_d    = (sw_q < avail_w) ? sw_q : avail_w;
    assign eh_d    = (sh_q < avail_h) ? sh_q : avail_h;
    assign base_d  = 19'(sy_q) * 19'd100 + 19'(sx_q) + 19'd1;

    assign last_col = (col_q == ew_q - 8'd1);
    assign last_row = (row_q == eh_q - 8'd1);

    always_comb begin
        state_d   = state_q;
        fill_done = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SETUP;
            S_SETUP: begin
                fill_done = empty;
                state_d   = empty ? S_IDLE : S_FILL;
            end
            S_FILL:  if (last_col && last_row) begin
                fill_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        case (bus_addr)
            3'd0:    rdata_d = {9'd0, y0_q, 9'd0, x0_q};
            3'd1:    rdata_d = {8'd0, h_q, 8'd0, w_q};
            3'd2:    rdata_d = {24'd0, color_q};
            3'd3:    rdata_d = {29'd0, donef_q, drop_q, busy};
            default: rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q <= '0; y0_q <= '0; w_q <= '0; h_q <= '0; color_q <= '0;
            sx_q <= '0; sy_q <= '0; sw_q <= '0; sh_q <= '0; scolor_q <= '0;
            ew_q <= '0; eh_q <= '0; col_q <= '0; row_q <= '0; row_base_q <= '0;
            pix_we_q <= 1'b0; pix_addr_q <= '0; pix_data_q <= '0;
            done_q <= 1'b0; drop_q <= 1'b0; donef_q <= 1'b0; rdata_q <= '0;
        end else begin
            if (bus_we) begin
                case (bus_addr)
                    3'd0: begin x0_q <= bus_wdata[6:0]; y0_q <= bus_wdata[22:16]; end
                    3'd1: begin w_q <= bus_wdata[7:0]; h_q <= bus_wdata[23:16]; end
                    3'd2: color_q <= bus_wdata[7:0];
                    default: ;
                endcase
            end
            if (start) begin
                sx_q <= x0_q; sy_q <= y0_q; sw_q <= w_q; sh_q <= h_q; scolor_q <= color_q;
            end
            if (state_q == S_SETUP) begin
                ew_q <= ew_d; eh_q <= eh_d;
                col_q <= '0; row_q <= '0;
                row_base_q <= base_d;
            end else if (state_q == S_FILL) begin
                // Row base steps by one framebuffer row; no multiply inside the loop.
                if (last_col) begin
                    col_q      <= '0;
                    row_q      <= row_q + 8'd1;
                    row_base_q <= row_base_q + 19'd100;
                end else begin
                    col_q <= col_q + 8'd1;
                end
            end
            pix_we_q   <= wr_pix && !busy && pix_ok;
            pix_addr_q <= 19'(bus_wdata[22:16]) * 19'd100 + 19'(bus_wdata[6:0]) + 19'd1;
            pix_data_q <= bus_wdata[31:24];
            done_q     <= fill_done;
            // A flag event on the same edge as a status read survives the clear.
            if (wr_pix && busy) drop_q <= 1'b1;
            else if (rd_status) drop_q <= 1'b0;
            if (fill_done)      donef_q <= 1'b1;
            else if (rd_status) donef_q <= 1'b0;
            if (bus_re) rdata_q <= rdata_d;
        end
    end

    always_comb begin
        write_enable  = (state_q == S_FILL) || pix_we_q;
        write_address = '0;
        write_data    = '0;
        if (state_q == S_FILL) begin
            write_address = row_base_q + 19'(col_q);
            write_data    = scolor_q;
        end else if (pix_we_q) begin
            write_address = pix_addr_q;
            write_data    = pix_data_q;
        end
    end

    assign done      = done_q;
    assign bus_rdata = rdata_q;
endmodule
